// File: rtl/exec_mem_seq_pkg.sv
// Shared definitions for the exec memory/IO access sequencer: FSM states and
// Wishbone byte-lane select encodings.
package exec_mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;
  localparam logic [1:0] SEL_WORD = 2'b11;

  // Word accesses at odd addresses take the high lane first, then the low lane.
  function automatic logic [1:0] lane_sel(input logic byteop, input logic a0);
    if (!byteop && !a0) return SEL_WORD;
    if (byteop && !a0)  return SEL_LO;
    return SEL_HI;
  endfunction

endpackage

// File: rtl/exec_mem_seq.sv
// Exec-stage memory/IO sequencer onto a 16-bit Wishbone-classic bus: splits
// odd-address word accesses into two lane phases, steers lanes, optional timeout.
module exec_mem_seq
  import exec_mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned MAX_WAIT = 0,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wr_data,
  input  logic              we,
  input  logic              m_io,
  input  logic              byteop,
  output logic [15:0]       memout,
  output logic              mem_rdy,
  output logic              bus_err,
  output logic [ADDR_W-2:0] wb_adr_o,
  output logic [15:0]       wb_dat_o,
  input  logic [15:0]       wb_dat_i,
  output logic [1:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_tga_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i
);

  localparam int unsigned       WA_W       = ADDR_W - 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM   = WAIT_W'(MAX_WAIT);
  localparam bit                TIMEOUT_EN = (MAX_WAIT != 0);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wr_hi_q;
  logic              we_q, io_q, byte_q, split_q;
  logic [7:0]        rd_lo_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timed_out;
  logic [15:0]       rd_data;

  // I/O space wraps within 16 bits; memory wraps within the full word space.
  function automatic logic [WA_W-1:0] word_adr(input logic [ADDR_W-1:0] a,
                                               input logic io, input logic inc);
    logic [14:0]     io_w;
    logic [WA_W-1:0] mem_w;
    io_w  = a[15:1] + {14'd0, inc};
    mem_w = a[ADDR_W-1:1] + WA_W'(inc);
    return io ? WA_W'(io_w) : mem_w;
  endfunction

  always_comb begin
    timed_out = TIMEOUT_EN && (wait_cnt == WAIT_LIM) && !wb_ack_i;
    rd_data   = wb_dat_i;
    if (byte_q)
      rd_data = {8'h00, addr_q[0] ? wb_dat_i[15:8] : wb_dat_i[7:0]};
    else if (split_q)
      rd_data = {wb_dat_i[7:0], rd_lo_q};
    if (timed_out)
      rd_data = byte_q ? 16'h00FF : 16'hFFFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wr_hi_q  <= '0;
      we_q     <= 1'b0;
      io_q     <= 1'b0;
      byte_q   <= 1'b0;
      split_q  <= 1'b0;
      rd_lo_q  <= '0;
      wait_cnt <= '0;
      memout   <= '0;
      mem_rdy  <= 1'b0;
      bus_err  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= SEL_NONE;
      wb_we_o  <= 1'b0;
      wb_tga_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end else begin
      mem_rdy <= 1'b0;
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            addr_q   <= addr;
            wr_hi_q  <= wr_data[15:8];
            we_q     <= we;
            io_q     <= m_io;
            byte_q   <= byteop;
            split_q  <= !byteop && addr[0];
            wait_cnt <= '0;
            wb_adr_o <= word_adr(addr, m_io, 1'b0);
            wb_sel_o <= lane_sel(byteop, addr[0]);
            wb_dat_o <= (byteop || addr[0]) ? {2{wr_data[7:0]}} : wr_data;
            wb_we_o  <= we;
            wb_tga_o <= m_io;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= PH1;
          end
        end
        PH1, PH2: begin
          if (state == PH1 && split_q && wb_ack_i) begin
            // cyc/stb stay asserted: second half follows with no idle cycle.
            rd_lo_q  <= wb_dat_i[15:8];
            wait_cnt <= '0;
            wb_adr_o <= word_adr(addr_q, io_q, 1'b1);
            wb_sel_o <= SEL_LO;
            wb_dat_o <= {2{wr_hi_q}};
            state    <= PH2;
          end else if (wb_ack_i || timed_out) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_tga_o <= 1'b0;
            wb_sel_o <= SEL_NONE;
            mem_rdy  <= 1'b1;
            bus_err  <= timed_out;
            if (!we_q)
              memout <= rd_data;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_mem_seq.sv
// Scoreboard bench for exec_mem_seq: directed accesses push expected bus phases
// and completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_exec_mem_seq;

  localparam int unsigned ADDR_W   = 20;
  localparam int unsigned MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wr_data;
  logic              we, m_io, byteop;
  logic [15:0]       memout;
  logic              mem_rdy, bus_err;
  logic [ADDR_W-2:0] wb_adr_o;
  logic [15:0]       wb_dat_o, wb_dat_i;
  logic [1:0]        wb_sel_o;
  logic              wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o, wb_ack_i;

  exec_mem_seq #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wr_data(wr_data), .we(we),
    .m_io(m_io), .byteop(byteop), .memout(memout), .mem_rdy(mem_rdy),
    .bus_err(bus_err), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] adr;
    logic [1:0]  sel;
    logic        we;
    logic        tga;
    logic [15:0] dat;
    logic [15:0] mask;
  } bus_exp_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;
  int req_edge = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bus_exp_t bx(input logic [18:0] adr, input logic [1:0] sel,
                                  input logic w, input logic t,
                                  input logic [15:0] dat, input logic [15:0] mask);
    bus_exp_t e;
    e.adr = adr; e.sel = sel; e.we = w; e.tga = t; e.dat = dat; e.mask = mask;
    return e;
  endfunction

  function automatic rsp_exp_t rx(input logic [15:0] d, input logic e, input int lat);
    rsp_exp_t r;
    r.data = d; r.err = e; r.lat = lat;
    return r;
  endfunction

  // Monitor: compares each acknowledged bus phase and each completion pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
        if (bus_q.size() == 0) begin
          check("bus_phase_unexpected", 32'd1, 32'd0);
        end else begin
          bus_exp_t e;
          e = bus_q.pop_front();
          check("wb_adr_o", 32'(wb_adr_o), 32'(e.adr));
          check("wb_sel_o", 32'(wb_sel_o), 32'(e.sel));
          check("wb_we_o",  32'(wb_we_o),  32'(e.we));
          check("wb_tga_o", 32'(wb_tga_o), 32'(e.tga));
          if (e.mask != 16'h0000)
            check("wb_dat_o", 32'(wb_dat_o & e.mask), 32'(e.dat));
        end
      end
      if (mem_rdy) begin
        if (rsp_q.size() == 0) begin
          check("mem_rdy_unexpected", 32'd1, 32'd0);
        end else begin
          rsp_exp_t r;
          r = rsp_q.pop_front();
          check("memout",  32'(memout),  32'(r.data));
          check("bus_err", 32'(bus_err), 32'(r.err));
          check("latency", 32'(edge_cnt - req_edge + 1), 32'(r.lat));
        end
      end
    end
  end

  // Slave side of one bus phase; waits < 0 means the slave never answers.
  task automatic phase(input int waits, input logic [15:0] rdat);
    if (waits < 0) begin
      int n = 0;
      while (wb_cyc_o && n < 30) begin
        n++;
        @(posedge clk); #1;
      end
      check("timeout_cyc_cycles", 32'(n), 32'(MAX_WAIT + 1));
    end else begin
      repeat (waits) begin
        @(posedge clk); #1;
      end
      wb_ack_i = 1'b1;
      wb_dat_i = rdat;
      @(posedge clk); #1;
      wb_ack_i = 1'b0;
    end
  endtask

  task automatic access(input logic [19:0] a, input logic [15:0] d, input logic w,
                        input logic io, input logic bo,
                        input int w1, input logic [15:0] r1,
                        input int w2, input logic [15:0] r2);
    @(posedge clk); #1;
    addr = a; wr_data = d; we = w; m_io = io; byteop = bo; req = 1'b1;
    req_edge = edge_cnt;
    @(posedge clk); #1;
    phase(w1, r1);
    if (!bo && a[0] && w1 >= 0)
      phase(w2, r2);
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_memout"},  32'(memout),   32'd0);
    check({tag, "_mem_rdy"}, 32'(mem_rdy),  32'd0);
    check({tag, "_bus_err"}, 32'(bus_err),  32'd0);
    check({tag, "_adr"},     32'(wb_adr_o), 32'd0);
    check({tag, "_dat"},     32'(wb_dat_o), 32'd0);
    check({tag, "_sel"},     32'(wb_sel_o), 32'd0);
    check({tag, "_we"},      32'(wb_we_o),  32'd0);
    check({tag, "_tga"},     32'(wb_tga_o), 32'd0);
    check({tag, "_cyc"},     32'(wb_cyc_o), 32'd0);
    check({tag, "_stb"},     32'(wb_stb_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; wr_data = '0; we = 1'b0; m_io = 1'b0;
    byteop = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Aligned word read.
    bus_q.push_back(bx(19'h0091A, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000));
    rsp_q.push_back(rx(16'hBEEF, 1'b0, 3));
    access(20'h01234, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 16'hBEEF, 0, 16'h0000);

    // Split word write: memout keeps previous read.
    bus_q.push_back(bx(19'h00080, 2'b10, 1'b1, 1'b0, 16'h5A00, 16'hFF00));
    bus_q.push_back(bx(19'h00081, 2'b01, 1'b1, 1'b0, 16'h00A5, 16'h00FF));
    rsp_q.push_back(rx(16'hBEEF, 1'b0, 4));
    access(20'h00101, 16'hA55A, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 0, 16'h0000);

    // Split I/O read at 0xFFFF wraps to word 0.
    bus_q.push_back(bx(19'h07FFF, 2'b10, 1'b0, 1'b1, 16'h0000, 16'h0000));
    bus_q.push_back(bx(19'h00000, 2'b01, 1'b0, 1'b1, 16'h0000, 16'h0000));
    rsp_q.push_back(rx(16'h1234, 1'b0, 4));
    access(20'h0FFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 0, 16'h3400, 0, 16'h0012);

    // Byte read at odd address with two wait states.
    bus_q.push_back(bx(19'h00001, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h0000));
    rsp_q.push_back(rx(16'h0077, 1'b0, 5));
    access(20'h00003, 16'h0000, 1'b0, 1'b0, 1'b1, 2, 16'h7700, 0, 16'h0000);

    // Split memory read at top of memory wraps to word 0.
    bus_q.push_back(bx(19'h7FFFF, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h0000));
    bus_q.push_back(bx(19'h00000, 2'b01, 1'b0, 1'b0, 16'h0000, 16'h0000));
    rsp_q.push_back(rx(16'hCDAB, 1'b0, 4));
    access(20'hFFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 16'hAB00, 0, 16'h00CD);

    // Byte read at even address.
    bus_q.push_back(bx(19'h00023, 2'b01, 1'b0, 1'b0, 16'h0000, 16'h0000));
    rsp_q.push_back(rx(16'h0099, 1'b0, 3));
    access(20'h00046, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 16'h1199, 0, 16'h0000);

    // Ack in the same cycle the wait limit is reached completes normally.
    bus_q.push_back(bx(19'h00080, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000));
    rsp_q.push_back(rx(16'h4242, 1'b0, 7));
    access(20'h00100, 16'h0000, 1'b0, 1'b0, 1'b0, MAX_WAIT, 16'h4242, 0, 16'h0000);

    // Word read never acknowledged: abort.
    rsp_q.push_back(rx(16'hFFFF, 1'b1, 7));
    access(20'h00010, 16'h0000, 1'b0, 1'b0, 1'b0, -1, 16'h0000, 0, 16'h0000);

    // Following aligned word write completes normally.
    bus_q.push_back(bx(19'h00010, 2'b11, 1'b1, 1'b0, 16'h1357, 16'hFFFF));
    rsp_q.push_back(rx(16'hFFFF, 1'b0, 3));
    access(20'h00020, 16'h1357, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 0, 16'h0000);

    // Byte read never acknowledged: abort value is 00FF.
    rsp_q.push_back(rx(16'h00FF, 1'b1, 7));
    access(20'h00050, 16'h0000, 1'b0, 1'b0, 1'b1, -1, 16'h0000, 0, 16'h0000);

    // Byte write at even address replicates the byte on both lanes.
    bus_q.push_back(bx(19'h00022, 2'b01, 1'b1, 1'b0, 16'hC3C3, 16'hFFFF));
    rsp_q.push_back(rx(16'h00FF, 1'b0, 3));
    access(20'h00044, 16'h12C3, 1'b1, 1'b0, 1'b1, 0, 16'h0000, 0, 16'h0000);

    // Reset during PH2 of a split read; stray acks afterwards are ignored.
    bus_q.push_back(bx(19'h00100, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h0000));
    @(posedge clk); #1;
    addr = 20'h00201; we = 1'b0; m_io = 1'b0; byteop = 1'b0; req = 1'b1;
    @(posedge clk); #1;
    wb_ack_i = 1'b1; wb_dat_i = 16'h5600;
    @(posedge clk); #1;
    check("ph2_cyc_before_reset", 32'(wb_cyc_o), 32'd1);
    wb_ack_i = 1'b0; rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("midreset");
    rst = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 16'h0034;
    repeat (3) begin
      @(posedge clk); #1;
      check("stray_ack_mem_rdy", 32'(mem_rdy), 32'd0);
      check("stray_ack_cyc", 32'(wb_cyc_o), 32'd0);
    end
    wb_ack_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
